// File: rtl/pkt_stream_encoder_pkg.sv
// Shared types and constants for the packet stream encoder.
package pkt_stream_encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREFIX = 3'd1,
    ST_SRC    = 3'd2,
    ST_LEN    = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5
  } state_e;

  localparam int unsigned CSUM_SUM = 0;
  localparam int unsigned CSUM_XOR = 1;

  localparam logic [7:0] DEFAULT_PREFIX = 8'hA5;

  // One checksum accumulation step: modular add or xor.
  function automatic logic [7:0] csum_step(input int unsigned mode,
                                           input logic [7:0]  acc,
                                           input logic [7:0]  b);
    if (mode == CSUM_XOR) begin
      return acc ^ b;
    end
    return acc + b;
  endfunction

endpackage

// File: rtl/pkt_stream_encoder_rr_arbiter.sv
// Combinational round-robin grant: first set req bit at or after ptr, wrapping.
module pkt_stream_encoder_rr_arbiter #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [IDX_W-1:0] idx;
  logic [N-1:0]     sh;

  // Scan from the pointer position; the first hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    sh    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IDX_W'((32'(ptr) + i) % N);
      sh  = req >> idx;
      if (!valid && sh[0]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/pkt_stream_encoder.sv
// Round-robin multi-source message serialiser: PREFIX, SRC, LEN, DATA..., CSUM.
module pkt_stream_encoder
  import pkt_stream_encoder_pkg::*;
#(
  parameter int unsigned N_SRC     = 8,
  parameter logic [7:0]  PREFIX    = DEFAULT_PREFIX,
  parameter int unsigned CSUM_MODE = CSUM_SUM,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   have_msg_bus,
  input  logic [N_SRC-1:0]   src_enable,
  input  logic [8*N_SRC-1:0] data_bus,
  input  logic [8*N_SRC-1:0] len_bus,
  output logic [N_SRC-1:0]   rdreq_bus,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   pkt_cnt
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_e           state, state_nxt;
  logic [IDX_W-1:0] src_q, src_nxt;
  logic [IDX_W-1:0] ptr_q, ptr_nxt;
  logic [7:0]       len_q, len_nxt;
  logic [7:0]       cnt_q, cnt_nxt;
  logic [7:0]       csum_q, csum_nxt;
  logic [7:0]       tx_data_nxt;
  logic             tx_valid_nxt;
  logic [CNT_W-1:0] pkt_cnt_nxt;

  logic [IDX_W-1:0] gnt;
  logic             gnt_valid;
  logic [7:0]       head;
  logic [7:0]       len_sel;
  logic             accept;

  pkt_stream_encoder_rr_arbiter #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (have_msg_bus & src_enable),
    .ptr   (ptr_q),
    .grant (gnt),
    .valid (gnt_valid)
  );

  assign accept  = tx_valid & tx_ready;
  assign head    = 8'(data_bus >> (32'(src_q) * 32'd8));
  assign len_sel = 8'(len_bus >> (32'(gnt) * 32'd8));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      src_q    <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      csum_q   <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      src_q    <= src_nxt;
      ptr_q    <= ptr_nxt;
      len_q    <= len_nxt;
      cnt_q    <= cnt_nxt;
      csum_q   <= csum_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
      busy     <= (state_nxt != ST_IDLE);
      pkt_cnt  <= pkt_cnt_nxt;
    end
  end

  // Next-state, next-output and FIFO pop strobe; every step advances only on a transfer.
  always_comb begin
    state_nxt    = state;
    src_nxt      = src_q;
    ptr_nxt      = ptr_q;
    len_nxt      = len_q;
    cnt_nxt      = cnt_q;
    csum_nxt     = csum_q;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    pkt_cnt_nxt  = pkt_cnt;
    rdreq_bus    = '0;
    case (state)
      ST_IDLE: begin
        if (gnt_valid) begin
          src_nxt      = gnt;
          len_nxt      = len_sel;
          tx_data_nxt  = PREFIX;
          tx_valid_nxt = 1'b1;
          state_nxt    = ST_PREFIX;
        end
      end
      ST_PREFIX: begin
        if (accept) begin
          tx_data_nxt = 8'(src_q);
          csum_nxt    = 8'(src_q);
          state_nxt   = ST_SRC;
        end
      end
      ST_SRC: begin
        if (accept) begin
          tx_data_nxt = len_q;
          csum_nxt    = csum_step(CSUM_MODE, csum_q, len_q);
          state_nxt   = ST_LEN;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (len_q == 8'd0) begin
            tx_data_nxt = csum_q;
            state_nxt   = ST_CSUM;
          end else begin
            tx_data_nxt = head;
            rdreq_bus   = N_SRC'(1) << src_q;
            cnt_nxt     = 8'd1;
            csum_nxt    = csum_step(CSUM_MODE, csum_q, head);
            state_nxt   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (cnt_q < len_q) begin
            tx_data_nxt = head;
            rdreq_bus   = N_SRC'(1) << src_q;
            cnt_nxt     = cnt_q + 8'd1;
            csum_nxt    = csum_step(CSUM_MODE, csum_q, head);
          end else begin
            tx_data_nxt = csum_q;
            state_nxt   = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          tx_valid_nxt = 1'b0;
          cnt_nxt      = 8'd0;
          ptr_nxt      = (src_q == IDX_W'(N_SRC - 1)) ? '0 : src_q + IDX_W'(1);
          pkt_cnt_nxt  = pkt_cnt + CNT_W'(1);
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pkt_stream_encoder.sv
// Scoreboard bench for pkt_stream_encoder with a message-level reference model.
module tb_pkt_stream_encoder;

  localparam int N  = 8;
  localparam int CW = 16;

  typedef logic [7:0] byte_q_t[$];

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   have_msg_bus;
  logic [N-1:0]   src_enable;
  logic [8*N-1:0] data_bus;
  logic [8*N-1:0] len_bus;
  logic [N-1:0]   rdreq_bus;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;
  logic [CW-1:0]  pkt_cnt;

  // Second instance in XOR checksum mode, driven directly.
  logic [3:0]     have2;
  logic [3:0]     en2;
  logic [31:0]    data2;
  logic [31:0]    len2;
  logic [3:0]     rdreq2;
  logic [7:0]     tx_data2;
  logic           tx_valid2;
  logic           tx_ready2;
  logic           busy2;
  logic [CW-1:0]  pkt_cnt2;

  always #5 clk = ~clk;

  pkt_stream_encoder #(.N_SRC(N), .PREFIX(8'hA5), .CSUM_MODE(0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .have_msg_bus(have_msg_bus), .src_enable(src_enable),
    .data_bus(data_bus), .len_bus(len_bus), .rdreq_bus(rdreq_bus), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  pkt_stream_encoder #(.N_SRC(4), .PREFIX(8'hA5), .CSUM_MODE(1), .CNT_W(CW)) dut_xor (
    .clk(clk), .rst(rst), .have_msg_bus(have2), .src_enable(en2),
    .data_bus(data2), .len_bus(len2), .rdreq_bus(rdreq2), .tx_data(tx_data2),
    .tx_valid(tx_valid2), .tx_ready(tx_ready2), .busy(busy2), .pkt_cnt(pkt_cnt2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Source FIFOs as seen by the DUT, and the model's own copy of pending messages.
  logic [7:0] src_bytes [N][$];
  logic [7:0] src_lens  [N][$];
  logic [7:0] m_bytes   [N][$];
  logic [7:0] m_lens    [N][$];
  int         m_ptr  = 0;
  int         m_pkts = 0;
  logic [7:0] exp_q[$];
  int         mon_idx = 0;
  bit         bp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      have_msg_bus[i]    = (src_lens[i].size() != 0);
      len_bus[8*i +: 8]  = (src_lens[i].size() != 0) ? src_lens[i][0] : 8'h00;
      data_bus[8*i +: 8] = (src_bytes[i].size() != 0) ? src_bytes[i][0] : 8'h00;
    end
  endtask

  // Whole packet for one message, checksum from plain sum or xor-fold.
  task automatic build_pkt(input int mode, input int s, input byte_q_t d, output byte_q_t o);
    int         total;
    logic [7:0] x;
    o = {};
    o.push_back(8'hA5);
    o.push_back(8'(s));
    o.push_back(8'(d.size()));
    total = s + d.size();
    x = 8'(s) ^ 8'(d.size());
    foreach (d[k]) begin
      o.push_back(d[k]);
      total += int'(d[k]);
      x ^= d[k];
    end
    o.push_back((mode == 1) ? x : 8'(total % 256));
  endtask

  task automatic add_msg(input int s, input byte_q_t d);
    src_lens[s].push_back(8'(d.size()));
    m_lens[s].push_back(8'(d.size()));
    foreach (d[k]) begin
      src_bytes[s].push_back(d[k]);
      m_bytes[s].push_back(d[k]);
    end
  endtask

  task automatic add_rand_msg(input int s, input int l);
    byte_q_t d;
    d = {};
    for (int k = 0; k < l; k++) d.push_back(8'($urandom_range(0, 255)));
    add_msg(s, d);
  endtask

  // Serve every pending enabled message in round-robin order; nothing arrives meanwhile.
  task automatic start_batch(input logic [N-1:0] mask);
    int      pick;
    byte_q_t d;
    byte_q_t pkt;
    src_enable = mask;
    for (int guard = 0; guard < 256; guard++) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && mask[(m_ptr + k) % N] && m_lens[(m_ptr + k) % N].size() != 0)
          pick = (m_ptr + k) % N;
      end
      if (pick < 0) break;
      d = {};
      for (int k = int'(m_lens[pick].pop_front()); k > 0; k--) d.push_back(m_bytes[pick].pop_front());
      build_pkt(0, pick, d, pkt);
      foreach (pkt[k]) exp_q.push_back(pkt[k]);
      m_ptr = (pick + 1) % N;
      m_pkts++;
    end
    drive_src();
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (!(exp_q.size() == 0 && !busy && !tx_valid) && c < 600) begin
      tick();
      c++;
    end
    if (c >= 600) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d bytes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
    check({name, "_pkt_cnt"}, 32'(pkt_cnt), 32'(CW'(m_pkts)));
  endtask

  task automatic flush_all();
    for (int i = 0; i < N; i++) begin
      src_bytes[i].delete();
      src_lens[i].delete();
      m_bytes[i].delete();
      m_lens[i].delete();
    end
    exp_q.delete();
    m_ptr  = 0;
    m_pkts = 0;
    drive_src();
  endtask

  // Sink handshake: random backpressure when enabled.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every transferred byte with the scoreboard and checks handshake rules.
  initial begin : monitor
    int         idx, cur_src, cur_len, rd_cnt, hdr;
    bit         stalled, gap1, gap2, req_nz;
    logic [7:0] held;
    logic [N-1:0] pop_mask;
    idx = 0; cur_src = 0; cur_len = 0; rd_cnt = 0;
    stalled = 0; gap1 = 0; gap2 = 0; req_nz = 0; held = '0;
    forever begin
      @(negedge clk);
      pop_mask = '0;
      hdr = -1;
      if (rst) begin
        idx = 0; rd_cnt = 0; stalled = 0; gap1 = 0; gap2 = 0;
      end else begin
        if (stalled) begin
          check("stall_valid_held", 32'(tx_valid), 32'd1);
          check("stall_data_held", 32'(tx_data), 32'(held));
        end
        if (gap2) begin
          check("gap_restart", 32'(tx_valid), 32'(req_nz));
          gap2 = 0;
        end
        if (gap1) begin
          check("gap_idle", 32'(tx_valid), 32'd0);
          req_nz = |(have_msg_bus & src_enable);
          gap1 = 0;
          gap2 = 1;
        end
        if (tx_valid) check("busy_with_valid", 32'(busy), 32'd1);
        if (rdreq_bus != '0) begin
          check("rdreq_only_on_transfer", 32'(tx_valid & tx_ready), 32'd1);
          check("rdreq_onehot_src", 32'(rdreq_bus), 32'(N'(1) << cur_src));
          rd_cnt++;
          pop_mask = rdreq_bus;
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h, expected no transfer", tx_data);
          end else begin
            check($sformatf("byte_idx%0d", idx), 32'(tx_data), 32'(exp_q.pop_front()));
          end
          if (idx == 1) begin
            cur_src = int'(tx_data);
            hdr = cur_src;
          end
          if (idx == 2) cur_len = int'(tx_data);
          if (idx >= 3 && idx == 3 + cur_len) begin
            check("rdreq_count", 32'(rd_cnt), 32'(cur_len));
            rd_cnt = 0;
            idx = 0;
            gap1 = 1;
          end else begin
            idx++;
          end
        end
        stalled = tx_valid && !tx_ready;
        held = tx_data;
      end
      mon_idx = idx;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (pop_mask[i] && src_bytes[i].size() != 0) void'(src_bytes[i].pop_front());
      if (hdr >= 0 && hdr < N && src_lens[hdr].size() != 0) void'(src_lens[hdr].pop_front());
      drive_src();
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // XOR instance: one message on src 1, collected and compared byte by byte.
  task automatic run_xor();
    byte_q_t d, expd, got;
    bit      pop;
    d = {8'hF0, 8'h0F};
    build_pkt(1, 1, d, expd);
    got = {};
    en2 = 4'hF;
    len2 = 32'h0000_0200;
    data2 = {16'h0, d[0], 8'h00};
    have2 = 4'b0010;
    for (int c = 0; c < 40 && got.size() < expd.size(); c++) begin
      @(negedge clk);
      if (tx_valid2 && tx_ready2) got.push_back(tx_data2);
      pop = rdreq2[1];
      @(posedge clk);
      #1;
      if (pop && d.size() != 0) void'(d.pop_front());
      data2[15:8] = (d.size() != 0) ? d[0] : 8'h00;
      if (got.size() != 0) have2 = 4'b0000;
    end
    check("xor_len", 32'(got.size()), 32'(expd.size()));
    for (int k = 0; k < expd.size() && k < got.size(); k++)
      check($sformatf("xor_byte%0d", k), 32'(got[k]), 32'(expd[k]));
    repeat (3) tick();
    check("xor_pkt_cnt", 32'(pkt_cnt2), 32'd1);
    check("xor_busy_done", 32'(busy2), 32'd0);
  endtask

  initial begin : main
    int c;
    logic [N-1:0] mask;
    rst = 1'b1;
    src_enable = '0;
    have2 = '0; en2 = '0; data2 = '0; len2 = '0; tx_ready2 = 1'b1;
    flush_all();
    repeat (2) tick();
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdreq", 32'(rdreq_bus), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single message, then a zero-length one.
    add_msg(2, '{8'h01, 8'h02, 8'h03});
    start_batch('1);
    wait_drain("single");
    add_msg(5, '{});
    start_batch('1);
    wait_drain("zero_len");

    // Reset in the middle of the data phase.
    add_rand_msg(4, 6);
    start_batch('1);
    c = 0;
    while (mon_idx < 4 && c < 100) begin
      tick();
      c++;
    end
    check("reach_data_phase", 32'(mon_idx >= 4), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush_all();
    @(negedge clk);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rdreq", 32'(rdreq_bus), 32'd0);
    check("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    tick();

    // Two sources at once from pointer 0.
    add_rand_msg(0, 2);
    add_rand_msg(1, 3);
    start_batch('1);
    wait_drain("pair");

    // Masked source is held back until enabled.
    add_rand_msg(3, 2);
    add_rand_msg(6, 1);
    start_batch(8'hF7);
    wait_drain("masked");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("masked_idle", 32'(tx_valid), 32'd0);
    end
    tick();
    start_batch('1);
    wait_drain("unmasked");

    // Backpressure on a length-4 packet.
    bp_en = 1'b1;
    add_rand_msg(7, 4);
    start_batch('1);
    wait_drain("backpressure");

    // Random batches with random masks and backpressure; last batch drains all.
    for (int b = 0; b < 8; b++) begin
      bp_en = 1'($urandom_range(0, 1));
      for (int m = $urandom_range(1, 6); m > 0; m--)
        add_rand_msg($urandom_range(0, N - 1), $urandom_range(0, 8));
      mask = (b == 7) ? '1 : N'($urandom_range(0, 255));
      start_batch(mask);
      wait_drain($sformatf("rand%0d", b));
    end
    bp_en = 1'b0;
    tick();

    run_xor();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
